// File: rtl/seg7_scan_reader_if.sv
// Interface for the scanned 7-segment display bus and the digits recovered from it.
// The master drives the display pins; the slave is the reader.
interface seg7_scan_reader_if;
  logic [7:0]  LED;
  logic [3:0]  AN;
  logic [15:0] DIGIT;
  logic [3:0]  DP;
  logic [3:0]  VALID;
  logic [3:0]  ERR;
  logic        UPD;
  logic [1:0]  UPD_IDX;

  modport master (
    output LED, AN,
    input  DIGIT, DP, VALID, ERR, UPD, UPD_IDX
  );

  modport slave (
    input  LED, AN,
    output DIGIT, DP, VALID, ERR, UPD, UPD_IDX
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus,
// capturing each digit once per stable dwell and ageing out stale digits.
module seg7_scan_reader #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned STALE  = 4096
) (
  input logic               CLK,
  input logic               RST,
  seg7_scan_reader_if.slave bus
);

  localparam logic [7:0]  L_SETTLE    = 8'(SETTLE);
  localparam logic [7:0]  L_SETTLE_M1 = 8'(SETTLE - 1);
  localparam bit          L_STALE_EN  = (STALE != 0);
  localparam logic [15:0] L_STALE_M1  = 16'(STALE - 1);

  logic [7:0]  r_s_led, r_p_led;
  logic [3:0]  r_s_an, r_p_an;
  logic [7:0]  r_cnt;
  logic [15:0] r_stale [4];
  logic [15:0] r_digit;
  logic [3:0]  r_dp, r_valid, r_err;
  logic        r_upd;
  logic [1:0]  r_upd_idx;

  logic       w_sel, w_same, w_cap;
  logic [1:0] w_idx;
  logic [3:0] w_nib;
  logic       w_legal, w_bad;

  always_comb begin
    w_sel = 1'b1;
    w_idx = '0;
    case (r_s_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_sel = 1'b0;
    endcase
  end

  assign w_same = ({r_s_an, r_s_led} == {r_p_an, r_p_led});
  // Counter saturates at SETTLE, so the SETTLE-1 -> SETTLE step happens once per dwell.
  assign w_cap  = w_sel && w_same && (r_cnt == L_SETTLE_M1);

  always_comb begin
    w_nib   = 4'hE;
    w_legal = 1'b0;
    w_bad   = 1'b1;
    case (r_s_led[7:1])
      7'b0000001: begin w_nib = 4'd0; w_legal = 1'b1; w_bad = 1'b0; end
      7'b1001111: begin w_nib = 4'd1; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0010010: begin w_nib = 4'd2; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0000110: begin w_nib = 4'd3; w_legal = 1'b1; w_bad = 1'b0; end
      7'b1001100: begin w_nib = 4'd4; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0100100: begin w_nib = 4'd5; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0100000: begin w_nib = 4'd6; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0001101: begin w_nib = 4'd7; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0000000: begin w_nib = 4'd8; w_legal = 1'b1; w_bad = 1'b0; end
      7'b0001100: begin w_nib = 4'd9; w_legal = 1'b1; w_bad = 1'b0; end
      7'b1111111: begin w_nib = 4'hF; w_bad = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s_led <= '1;
      r_s_an  <= '1;
      r_p_led <= '1;
      r_p_an  <= '1;
      r_cnt   <= '0;
    end else begin
      r_s_led <= bus.LED;
      r_s_an  <= bus.AN;
      r_p_led <= r_s_led;
      r_p_an  <= r_s_an;
      if (!w_sel || !w_same)
        r_cnt <= '0;
      else if (r_cnt != L_SETTLE)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_digit   <= '1;
      r_dp      <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      for (int unsigned i = 0; i < 4; i++)
        r_stale[i] <= '0;
    end else begin
      r_upd <= w_cap;
      if (w_cap)
        r_upd_idx <= w_idx;
      for (int unsigned i = 0; i < 4; i++) begin
        // A capture on the expiry edge takes priority over the stale clear.
        if (w_cap && (w_idx == 2'(i))) begin
          r_stale[i]       <= '0;
          r_digit[4*i +: 4] <= w_nib;
          r_dp[i]          <= ~r_s_led[0];
          r_valid[i]       <= w_legal;
          r_err[i]         <= w_bad;
        end else begin
          if (r_stale[i] != '1)
            r_stale[i] <= r_stale[i] + 16'd1;
          if (L_STALE_EN && (r_stale[i] == L_STALE_M1))
            r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.DIGIT   = r_digit;
  assign bus.DP      = r_dp;
  assign bus.VALID   = r_valid;
  assign bus.ERR     = r_err;
  assign bus.UPD     = r_upd;
  assign bus.UPD_IDX = r_upd_idx;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with SETTLE=4, STALE=64.
module tb_seg7_scan_reader;

  logic CLK;
  logic RST;
  seg7_scan_reader_if bus ();

  seg7_scan_reader #(.SETTLE(4), .STALE(64)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         upd_cnt = 0;
  logic [7:0] idx_log = '0;

  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.UPD === 1'b1) begin
      upd_cnt++;
      idx_log = {idx_log[5:0], bus.UPD_IDX};
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] led);
    bus.AN  = an;
    bus.LED = led;
  endtask

  initial begin
    // Reset with a legal digit-0 pattern already on the pins
    RST = 1'b1;
    drive(4'b1110, 8'b00000011);
    ticks(3);
    chk("rst_digit", bus.DIGIT, 16'hFFFF);
    chk("rst_valid", bus.VALID, 4'h0);
    chk("rst_err",   bus.ERR,   4'h0);
    chk("rst_dp",    bus.DP,    4'h0);
    chk("rst_upd",   bus.UPD,   1'b0);
    chk("rst_no_upd_in_reset", upd_cnt, 0);

    // Single capture: edges E0..E0+4 no UPD, UPD after E0+5
    RST = 1'b0;
    upd_cnt = 0;
    ticks(5);
    chk("cap0_early", upd_cnt, 0);
    tick();
    chk("cap0_upd",    bus.UPD,        1'b1);
    chk("cap0_idx",    bus.UPD_IDX,    2'd0);
    chk("cap0_nib",    bus.DIGIT[3:0], 4'h0);
    chk("cap0_valid",  bus.VALID,      4'b0001);
    chk("cap0_dp",     bus.DP,         4'b0000);
    ticks(6);
    chk("cap0_once",   upd_cnt,        1);
    chk("cap0_upd_lo", bus.UPD,        1'b0);

    // Full scan, 8 cycles per digit
    upd_cnt = 0;
    idx_log = '0;
    drive(4'b1110, 8'b10011111); ticks(8);
    drive(4'b1101, 8'b00100101); ticks(8);
    drive(4'b1011, 8'b00001100); ticks(8);
    drive(4'b0111, 8'b00011001); ticks(8);
    chk("scan_cnt",   upd_cnt,   4);
    chk("scan_idx",   idx_log,   8'h1B);
    chk("scan_digit", bus.DIGIT, 16'h9321);
    chk("scan_valid", bus.VALID, 4'b1111);
    chk("scan_dp",    bus.DP,    4'b0100);
    chk("scan_err",   bus.ERR,   4'b0000);

    // Glitch: held 4 cycles then changed; then ghosting on two anodes
    upd_cnt = 0;
    drive(4'b1101, 8'b10011111); ticks(4);
    drive(4'b1111, 8'b11111111); ticks(2);
    drive(4'b1100, 8'b00000011); ticks(20);
    chk("ghost_no_upd", upd_cnt,   0);
    chk("ghost_digit",  bus.DIGIT, 16'h9321);
    chk("ghost_err",    bus.ERR,   4'b0000);
    chk("ghost_dp",     bus.DP,    4'b0100);

    // Illegal code on digit 2, then blank
    upd_cnt = 0;
    drive(4'b1011, 8'b01100001); ticks(8);
    chk("ill_err",   bus.ERR,          4'b0100);
    chk("ill_valid", bus.VALID[2],     1'b0);
    chk("ill_nib",   bus.DIGIT[11:8],  4'hE);
    chk("ill_dp",    bus.DP[2],        1'b0);
    chk("ill_keep",  bus.DIGIT[15:12], 4'h9);
    drive(4'b1011, 8'b11111111); ticks(8);
    chk("blank_nib",   bus.DIGIT[11:8], 4'hF);
    chk("blank_err",   bus.ERR[2],      1'b0);
    chk("blank_valid", bus.VALID[2],    1'b0);
    chk("ill_blank_cnt", upd_cnt,       2);

    // Stale: capture 5 on digit 3, VALID[3] drops 64 cycles later
    drive(4'b1111, 8'b11111111); ticks(2);
    drive(4'b0111, 8'b01001001); ticks(6);
    chk("st_upd",   bus.UPD,     1'b1);
    chk("st_idx",   bus.UPD_IDX, 2'd3);
    chk("st_valid", bus.VALID[3], 1'b1);
    drive(4'b1111, 8'b11111111);
    ticks(63);
    chk("st_before", bus.VALID[3], 1'b1);
    tick();
    chk("st_drop",   bus.VALID[3],     1'b0);
    chk("st_keep",   bus.DIGIT[15:12], 4'h5);
    chk("st_err",    bus.ERR[3],       1'b0);

    // Recapture landing exactly on the expiry edge keeps VALID
    drive(4'b0111, 8'b01001001); ticks(6);
    chk("rc_first", bus.UPD, 1'b1);
    drive(4'b1111, 8'b11111111); ticks(58);
    upd_cnt = 0;
    drive(4'b0111, 8'b01001001); ticks(5);
    chk("rc_pre_valid", bus.VALID[3], 1'b1);
    chk("rc_pre_upd",   upd_cnt,      0);
    tick();
    chk("rc_upd",   bus.UPD,      1'b1);
    chk("rc_valid", bus.VALID[3], 1'b1);
    drive(4'b1111, 8'b11111111); ticks(5);
    chk("rc_hold",  bus.VALID[3], 1'b1);

    // Reset mid-dwell aborts; a fresh full dwell is needed afterwards
    drive(4'b1110, 8'b00000011); ticks(3);
    RST = 1'b1;
    tick();
    chk("mrst_digit", bus.DIGIT, 16'hFFFF);
    chk("mrst_valid", bus.VALID, 4'h0);
    RST = 1'b0;
    upd_cnt = 0;
    ticks(5);
    chk("mrst_early", upd_cnt, 0);
    tick();
    chk("mrst_upd", bus.UPD,        1'b1);
    chk("mrst_nib", bus.DIGIT[3:0], 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Recovers BCD digit values from a multiplexed, scanned 4-digit 7-segment display bus: active-low segment/DP lines plus active-low anode enables.
- Samples the bus, requires a stable dwell, and encodes each segment pattern back to BCD.
- Holds per-digit value, DP, valid and error flags.
- Used as an on-chip monitor/loopback checker behind the board display driver.

Parameters:
SETTLE, 4, identical consecutive samples beyond the first needed before capture (range 1..255)
STALE, 4096, cycles without a capture of a digit before its VALID clears; 0 disables (range 0..65535)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
LED  input  8  segment bus, active-low; [7:1]=a,b,c,d,e,f,g, [0]=dp
AN  input  4  anode enables, active-low; AN[i]=0 selects digit i
DIGIT  output  16  captured value per digit; digit i at [4i+3:4i]
DP  output  4  captured decimal point per digit, active-high (DP[i] = ~LED[0] at capture)
VALID  output  4  digit i holds a legal BCD capture that has not gone stale
ERR  output  4  last capture of digit i was an illegal pattern
UPD  output  1  one-cycle pulse on every capture
UPD_IDX  output  2  digit index of the capture; meaningful only while UPD=1

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous and active-high (RST).
- Input stage: LED and AN are registered once (S_LED, S_AN). Reset loads both with all-ones (idle, no digit).
- Selection: a sample is selectable only if exactly one bit of S_AN is 0. AN=1111 or two or more zero bits means no capture, and the dwell counter is held at 0.
- Dwell counter (8-bit):
  - Cleared when {S_AN,S_LED} differs from the previous registered sample, or when the sample is not selectable.
  - Otherwise increments, saturating at SETTLE.
- Capture:
  - Occurs on the edge where the counter goes from SETTLE-1 to SETTLE.
  - Fires exactly once per dwell. Further identical samples never re-capture; the same pattern recaptures only after a change.
- Latency: a value present at the pins before edge E0 and held through edge E0+SETTLE gives updated outputs and UPD=1 after edge E0+SETTLE+1. If the pins change earlier, there is no capture.
- Encoding of S_LED[7:1] to DIGIT nibble:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001101=7, 0000000=8, 0001100=9.
  - For these codes: VALID[i]=1, ERR[i]=0.
  - 1111111 (blank): nibble=F, VALID[i]=0, ERR[i]=0.
  - Any other code: nibble=E, VALID[i]=0, ERR[i]=1.
  - DP[i] is updated on every capture, whatever the code.
- Capture side effects: only digit i's fields change. UPD=1 and UPD_IDX=i for exactly that cycle.
- Stale timer (16-bit per digit):
  - Cleared on each capture of that digit; otherwise increments, saturating.
  - When it reaches STALE (STALE>0), VALID[i] clears. DIGIT, DP and ERR are retained.
  - A capture on the same edge as the stale expiry wins.
- Reset values: DIGIT=16'hFFFF, DP=0, VALID=0, ERR=0, UPD=0, UPD_IDX=0, all counters 0.
- Reset mid-dwell or mid-timeout aborts everything. After RST falls a full dwell is required again, with no capture from pre-reset samples.

Test Plan:
1. Reset: assert RST 3 cycles with LED=00000011, AN=1110 -> DIGIT=FFFF, VALID=0, ERR=0, DP=0, UPD=0; no UPD until edge E0+5 after release (SETTLE=4).
2. Single capture: AN=1110, LED=00000011 held 12 cycles from E0 -> exactly one UPD pulse after E0+5 with UPD_IDX=0; then DIGIT[3:0]=0, VALID=0001, DP=0000.
3. Full scan, 8 cycles per digit: digit0 LED=10011111, digit1 00100101, digit2 00001100 (dp on), digit3 00011001 -> DIGIT=16'h9321, VALID=1111, DP=0100, four UPD pulses with IDX 0,1,2,3.
4. Glitch and ghosting: digit1 pattern held 4 cycles then changed -> no UPD. AN=1100 held 20 cycles -> no UPD, outputs unchanged.
5. Illegal and blank codes: AN=1011, LED=01100001 -> ERR=0100, VALID[2]=0, DIGIT[11:8]=E. Then LED=11111111 -> DIGIT[11:8]=F, ERR[2]=0, VALID[2]=0.
6. Stale (STALE=64): capture 5 on digit3, then AN=1111 -> VALID[3] drops exactly 64 cycles after the UPD pulse, DIGIT[15:12]=5 retained. Recapture on the expiry cycle -> VALID[3] stays 1.
